// File: rtl/quad_fold_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_fold_pipe_if                                                          |
// | Sample-in / folded-sample-out bus for the quadrant/octant folder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface quad_fold_pipe_if #(
   parameter int W     = 17,
   parameter int TAG_W = 4
);
   logic                    ce;
   logic                    in_valid;
   logic        [2:0]       sector;
   logic signed [W-1:0]     sin_a;
   logic signed [W-1:0]     cos_a;
   logic        [TAG_W-1:0] in_tag;
   logic signed [W-1:0]     sin;
   logic signed [W-1:0]     cos;
   logic                    out_valid;
   logic        [TAG_W-1:0] out_tag;
   logic                    sat;

   modport master (
      output ce, in_valid, sector, sin_a, cos_a, in_tag,
      input  sin, cos, out_valid, out_tag, sat
   );

   modport slave (
      input  ce, in_valid, sector, sin_a, cos_a, in_tag,
      output sin, cos, out_valid, out_tag, sat
   );
endinterface
`default_nettype wire

// File: rtl/quad_fold_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_fold_pipe                                                             |
// | Two-stage sin/cos sector folder: swap/sign, then round-shift-saturate.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module quad_fold_pipe #(
   parameter int W      = 17,
   parameter int SHIFT  = 1,
   parameter int ROUND  = 0,
   parameter int OCTANT = 0,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   quad_fold_pipe_if.slave   bus
);
   localparam logic signed [W+1:0] c_one    = (W+2)'(1);
   localparam int                  c_rnd_sh = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [W+1:0] c_rnd    = (ROUND != 0 && SHIFT > 0) ? (c_one <<< c_rnd_sh) : '0;
   localparam logic signed [W+1:0] c_max    = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] c_min    = {3'b111, {(W-1){1'b0}}};

   logic signed [W-1:0]     w_s;
   logic signed [W-1:0]     w_c;
   logic        [1:0]       w_q;
   logic signed [W:0]       w_s_ext;
   logic signed [W:0]       w_c_ext;
   logic signed [W:0]       w_s_fold;
   logic signed [W:0]       w_c_fold;
   logic        [W:0]       w_sin_sc;
   logic        [W:0]       w_cos_sc;

   logic signed [W:0]       r_s1_sin;
   logic signed [W:0]       r_s1_cos;
   logic                    r_s1_valid;
   logic        [TAG_W-1:0] r_s1_tag;

   // Returns {clamped, value}; the extra headroom bit keeps the rounding add exact.
   function automatic logic [W:0] f_scale(input logic signed [W:0] x);
      logic signed [W+1:0] v_sum;
      v_sum = {x[W], x} + c_rnd;
      v_sum = v_sum >>> SHIFT;
      if (v_sum > c_max)
         return {1'b1, c_max[W-1:0]};
      else if (v_sum < c_min)
         return {1'b1, c_min[W-1:0]};
      else
         return {1'b0, v_sum[W-1:0]};
   endfunction

   always_comb begin
      w_s = bus.sin_a;
      w_c = bus.cos_a;
      if (OCTANT != 0 && bus.sector[0]) begin
         w_s = bus.cos_a;
         w_c = bus.sin_a;
      end
      w_q      = (OCTANT != 0) ? bus.sector[2:1] : bus.sector[1:0];
      // Widened before negation so the most negative sample folds without wrap.
      w_s_ext  = {w_s[W-1], w_s};
      w_c_ext  = {w_c[W-1], w_c};
      w_s_fold = (w_q == 2'd1 || w_q == 2'd2) ? -w_s_ext : w_s_ext;
      w_c_fold = w_q[1] ? -w_c_ext : w_c_ext;
   end

   always_comb begin
      w_sin_sc = f_scale(r_s1_sin);
      w_cos_sc = f_scale(r_s1_cos);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_sin      <= '0;
         r_s1_cos      <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_tag      <= '0;
         bus.sin       <= '0;
         bus.cos       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_tag   <= '0;
         bus.sat       <= 1'b0;
      end else if (bus.ce) begin
         r_s1_sin      <= w_s_fold;
         r_s1_cos      <= w_c_fold;
         r_s1_valid    <= bus.in_valid;
         r_s1_tag      <= bus.in_tag;
         bus.sin       <= w_sin_sc[W-1:0];
         bus.cos       <= w_cos_sc[W-1:0];
         bus.out_valid <= r_s1_valid;
         bus.out_tag   <= r_s1_tag;
         bus.sat       <= w_sin_sc[W] | w_cos_sc[W];
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_quad_fold_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quad_fold_pipe                                                          |
// | Four folder variants driven in parallel against a queued reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_quad_fold_pipe;
   localparam int W  = 17;
   localparam int TW = 4;
   localparam int ND = 4;

   typedef struct {
      longint s;
      longint c;
      int     tag;
      bit     v;
      bit     sat;
   } exp_t;

   // Variant table: 0 plain, 1 rounding, 2 no shift, 3 octant mode.
   function automatic int shift_of(input int d);
      return (d == 2) ? 0 : 1;
   endfunction
   function automatic int round_of(input int d);
      return (d == 1) ? 1 : 0;
   endfunction
   function automatic int oct_of(input int d);
      return (d == 3) ? 1 : 0;
   endfunction

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 ce;
   logic                 in_valid;
   logic        [2:0]    sector;
   logic signed [W-1:0]  sin_a;
   logic signed [W-1:0]  cos_a;
   logic        [TW-1:0] in_tag;

   logic signed [W-1:0]  o_sin [ND];
   logic signed [W-1:0]  o_cos [ND];
   logic                 o_val [ND];
   logic                 o_sat [ND];
   logic        [TW-1:0] o_tag [ND];

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb   [ND][$];
   exp_t last [ND];

   always #5 clk = ~clk;

   quad_fold_pipe_if #(.W(W), .TAG_W(TW)) bus [ND] ();

   for (genvar g = 0; g < ND; g++) begin : g_dut
      assign bus[g].ce       = ce;
      assign bus[g].in_valid = in_valid;
      assign bus[g].sector   = sector;
      assign bus[g].sin_a    = sin_a;
      assign bus[g].cos_a    = cos_a;
      assign bus[g].in_tag   = in_tag;
      assign o_sin[g] = bus[g].sin;
      assign o_cos[g] = bus[g].cos;
      assign o_val[g] = bus[g].out_valid;
      assign o_sat[g] = bus[g].sat;
      assign o_tag[g] = bus[g].out_tag;

      quad_fold_pipe #(
         .W(W), .SHIFT(shift_of(g)), .ROUND(round_of(g)), .OCTANT(oct_of(g)), .TAG_W(TW)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus[g])
      );
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint scale(input longint x, input int sh, input int rnd, output bit clamped);
      longint y;
      y = x + ((rnd != 0 && sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
      y = y >>> sh;
      clamped = 1'b0;
      if (y > 65535)  begin y = 65535;  clamped = 1'b1; end
      if (y < -65536) begin y = -65536; clamped = 1'b1; end
      return y;
   endfunction

   function automatic exp_t model(input int d, input logic [2:0] sec, input longint sa,
                                  input longint ca, input int tag, input bit v);
      exp_t   e;
      longint s, c;
      int     q;
      bit     ss, cs;
      s = sa;
      c = ca;
      if (oct_of(d) != 0 && sec[0]) begin
         s = ca;
         c = sa;
      end
      q = (oct_of(d) != 0) ? int'(sec[2:1]) : int'(sec[1:0]);
      if (q == 1 || q == 2) s = -s;
      if (q >= 2)           c = -c;
      e.s   = scale(s, shift_of(d), round_of(d), ss);
      e.c   = scale(c, shift_of(d), round_of(d), cs);
      e.sat = ss | cs;
      e.tag = tag;
      e.v   = v;
      return e;
   endfunction

   function automatic exp_t zero_e();
      exp_t e;
      e.s = 0; e.c = 0; e.tag = 0; e.v = 0; e.sat = 0;
      return e;
   endfunction

   task automatic cmp(input int d, input string ph, input exp_t e);
      chk($sformatf("d%0d_%s_sin", d, ph), longint'(o_sin[d]), e.s);
      chk($sformatf("d%0d_%s_cos", d, ph), longint'(o_cos[d]), e.c);
      chk($sformatf("d%0d_%s_valid", d, ph), longint'(o_val[d]), longint'(e.v));
      chk($sformatf("d%0d_%s_tag", d, ph), longint'(o_tag[d]), longint'(e.tag));
      chk($sformatf("d%0d_%s_sat", d, ph), longint'(o_sat[d]), longint'(e.sat));
   endtask

   // Every edge: a reset edge primes one zeroed stage-1 entry, an enabled edge
   // pops the output due now and pushes the sample entering stage 1.
   always @(posedge clk) begin
      logic            rst_c, ce_c, v_c;
      logic [2:0]      sec_c;
      longint          sa_c, ca_c;
      int              tag_c;
      exp_t            e;
      rst_c = rst; ce_c = ce; v_c = in_valid; sec_c = sector;
      sa_c = longint'(sin_a); ca_c = longint'(cos_a); tag_c = int'(in_tag);
      #1;
      for (int d = 0; d < ND; d++) begin
         if (rst_c) begin
            cmp(d, "rst", zero_e());
            sb[d].delete();
            sb[d].push_back(zero_e());
            last[d] = zero_e();
         end else if (ce_c) begin
            if (sb[d].size() == 0) begin
               chk($sformatf("d%0d_sb_empty", d), 0, 1);
            end else begin
               e = sb[d].pop_front();
               cmp(d, "out", e);
               last[d] = e;
            end
            sb[d].push_back(model(d, sec_c, sa_c, ca_c, tag_c, v_c));
         end else begin
            cmp(d, "hold", last[d]);
         end
      end
   end

   task automatic drive(input bit v, input logic [2:0] sec, input int sa, input int ca, input int tag);
      @(negedge clk);
      in_valid = v;
      sector   = sec;
      sin_a    = W'(sa);
      cos_a    = W'(ca);
      in_tag   = TW'(tag);
   endtask

   function automatic int rv();
      case ($urandom_range(0, 5))
         0:       return -65536;
         1:       return 65535;
         2:       return -1;
         default: return int'($urandom_range(0, 131071)) - 65536;
      endcase
   endfunction

   initial begin
      ce = 1'b1; in_valid = 1'b0; sector = '0; sin_a = '0; cos_a = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      drive(1, 3'd0, 1000, 30000, 4);
      drive(1, 3'd2, 1000, 30000, 5);
      drive(1, 3'd1, 1000, 30000, 6);
      drive(1, 3'd0, 3, 0, 7);
      drive(1, 3'd1, 3, 0, 8);
      drive(1, 3'd1, -65536, 0, 9);
      drive(1, 3'd0, 100, 0, 10);
      drive(1, 3'd1, 1000, 30000, 11);
      drive(1, 3'd5, 1000, 30000, 12);
      drive(1, 3'd3, 65535, -65536, 13);
      drive(1, 3'd6, -65536, 65535, 14);
      drive(0, 3'd7, 1234, -4321, 15);

      // Freeze for three cycles while junk is presented on the inputs.
      drive(1, 3'd0, 111, 222, 1);
      drive(1, 3'd1, 333, 444, 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ce = 1'b0;
         in_valid = 1'b1; sector = 3'($urandom); sin_a = W'(rv()); cos_a = W'(rv());
         in_tag = TW'($urandom);
      end
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b1; sector = 3'd2; sin_a = 555; cos_a = 666; in_tag = 3;
      drive(1, 3'd3, 777, 888, 4);
      drive(0, 3'd0, 0, 0, 0);
      drive(0, 3'd0, 0, 0, 0);

      // Reset with two samples in flight; ce low to show reset wins.
      drive(1, 3'd1, 9000, -9000, 9);
      drive(1, 3'd2, -700, 700, 10);
      @(negedge clk);
      rst = 1'b1; ce = 1'b0; in_valid = 1'b1; sin_a = 42; cos_a = 43; in_tag = 11;
      @(negedge clk);
      rst = 1'b0; ce = 1'b1; in_valid = 1'b0;
      repeat (3) drive(0, 3'd0, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ce       = ($urandom_range(0, 9) < 8);
         in_valid = 1'($urandom);
         sector   = 3'($urandom);
         sin_a    = W'(rv());
         cos_a    = W'(rv());
         in_tag   = TW'($urandom);
      end
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
